osd_cmd_arbiter: RTL and testbench
==================================

# osd_cmd_arbiter

Serializes OSD command packets from two requesters onto the single `io_osd`/`io_strobe`/`io_din` command port of the OSD overlay. Requesters are typically the HPS-side UIO bridge (port 0) and a local core-side status/menu engine (port 1). The block runs in `clk_sys` ahead of the OSD block. It applies round-robin arbitration per packet, frames each packet with `io_osd`, and paces strobes so that the OSD's rising-edge strobe detector sees every word exactly once.

## Interface
- `STROBE_GAP`, default 1: idle cycles with `io_strobe` low after each strobe-high cycle (≥1).
- `END_GAP`, default 2: cycles `io_osd` is held low between packets (≥2).
- `PRIO0`, default 0: 1 = port 0 has fixed priority; 0 = round-robin.
- `clk_sys`  in  1  system clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `req[1:0]`  in  2  per-port packet request; held until `gnt` is seen.
- `cmd0`, `cmd1`  in  8 each  command byte, sampled at grant.
- `len0`, `len1`  in  13 each  data word count (0..4352), sampled at grant.
- `dvalid[1:0]`  in  2  data word valid, per port.
- `dat0`, `dat1`  in  16 each  data word.
- `dready[1:0]`  out  2  one-cycle pulse per port when that port's word is consumed.
- `gnt[1:0]`  out  2  one-hot, asserted for the whole packet of the granted port.
- `done[1:0]`  out  2  one-cycle pulse when the packet's `END_GAP` completes.
- `io_osd`  out  1  packet frame to the OSD.
- `io_strobe`  out  1  word strobe.
- `io_din`  out  16  word to the OSD; the command is zero-extended to 16 bits.
- `busy`  out  1  state ≠ IDLE.

## Operation
- FSM states: IDLE → CMD → GAP → (DAT → GAP)* → WAIT (if data is not valid) → END → IDLE.
- **IDLE**
  - Arbitrates among the `req` bits.
  - Round-robin: the port other than the last-served port wins a tie.
  - Latches `cmd`, `len` and the grant, then goes to CMD.
- **CMD**
  - Drives `io_osd`=1, `io_strobe`=1, `io_din`={8'h00,cmd}. Lasts one cycle.
  - `io_osd` rises in the same cycle as the first strobe. This is legal because the OSD clears its counters only while `io_osd` is low.
- **GAP**
  - Holds `io_strobe`=0 for `STROBE_GAP` cycles.
  - Then: if the remaining count is 0 → END; else if `dvalid[g]` → DAT; else → WAIT.
- **WAIT**
  - Holds `io_osd`=1 and `io_strobe`=0 until `dvalid[g]` is high.
  - Has no timeout. A requester that stalls holds the port indefinitely.
- **DAT**
  - Drives `io_strobe`=1 and `io_din`=`dat[g]`, pulses `dready[g]`, and decrements the remaining count.
  - Goes to GAP.
- **END**
  - Drives `io_osd`=0 for `END_GAP` cycles. The OSD applies enable/disable on `~io_osd`.
  - Pulses `done[g]` on the last cycle, updates last-served, drops `gnt`, and returns to IDLE.
  - A new grant is possible on the following cycle.
- `len`=0: the packet is CMD, GAP, END only (for example OSDCMDDISABLE 0x40).
- `dvalid` on a non-granted port is ignored. `dready` is never asserted to it.
- `req` deasserted mid-packet is ignored. The packet always completes `len` words; data must be supplied.

## Timing
- Reset values:
  - FSM in IDLE.
  - `io_osd`=0, `io_strobe`=0, `io_din`=0.
  - `gnt`=0, `dready`=0, `done`=0, `busy`=0.
  - Last-served = port 1, so port 0 wins the first tie.
- All outputs are registered.
- Latency from `req` high in IDLE to `gnt` and the CMD strobe is 1 cycle.
- Minimum word period is 1+`STROBE_GAP` cycles (2 by default).
- Best-case packet length is 1 + (len+1)·(1+`STROBE_GAP`) − 1 + `END_GAP` cycles.
- `io_din` is stable while `io_strobe` is high. Between strobes it holds its last value.
- Reset asserted mid-packet:
  - All outputs drop immediately, including `io_osd`.
  - The OSD sees `io_osd` low, which aborts the packet. A partial buffer write remains; the requester must resend.
- Remaining-count decrement uses a 13-bit unsigned counter. It never wraps because END is entered at 0.

## Structure
- Shared package `osd_pkg`:
  - State enum.
  - Command constants: `OSD_CMD_WRITE`=8'h20, `OSD_CMD_ENABLE`=8'h41, `OSD_CMD_DISABLE`=8'h40, `OSD_HIRES_BIT`=3.
  - `OSD_BUF_WORDS`=4352.
- Sub-module `rr_arb2`: a 2-way round-robin/fixed-priority selector with a last-served register updated on `done`.

## Test plan
- **Reset:** deassert `reset_n` with `req`=2'b11 → `gnt`=01 one cycle later, `io_din`=cmd0, `io_osd`=1, `io_strobe`=1.
- **Write packet:** port 0, cmd 8'h20, len=4, data A1..A4 always valid.
  - Strobes at cycles 0, 2, 4, 6, 8.
  - `io_din` = 0020, A1, A2, A3, A4.
  - `io_osd` low 2 cycles, then `done[0]`.
- **Round-robin:** both ports request continuously with len=1 → grants alternate 01, 10, 01. With `PRIO0`=1, always 01.
- **Stall:** `dvalid[1]` low for 5 cycles before the second word → `io_osd` stays 1, no strobe, the word is strobed once with a single `dready` pulse.
- **Zero length:** cmd 8'h40, len=0 → exactly one strobe, then `io_osd` low ≥2 cycles.
- **Mid-packet reset:** assert `reset_n`=0 after the 2nd data strobe → all outputs 0 asynchronously; after release, a new packet starts cleanly with the command word.

Source files
------------

// File: rtl/osd_pkg.sv
// Shared types and constants for the OSD command path.
// Provides the arbiter state encoding, OSD command byte values and buffer sizing.
// No ports; imported by osd_cmd_arbiter and its sub-modules.
package osd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_GAP,
    ST_WAIT,
    ST_DAT,
    ST_END
  } osd_state_t;

  localparam logic [7:0] OSD_CMD_WRITE   = 8'h20;
  localparam logic [7:0] OSD_CMD_ENABLE  = 8'h41;
  localparam logic [7:0] OSD_CMD_DISABLE = 8'h40;
  localparam int         OSD_HIRES_BIT   = 3;

  localparam int OSD_BUF_WORDS = 4352;
  localparam int OSD_LEN_W     = 13;   // holds 0..OSD_BUF_WORDS
  localparam int OSD_CNT_W     = 8;    // strobe/end gap cycle counter

endpackage

// File: rtl/osd_cmd_arbiter_rr_arb2.sv
// rr_arb2: two-way request selector, round-robin or fixed port-0 priority.
// Latency: combinational select; last-served register updates on the done pulse.
// Ports: req (2 requests) / done (one-hot packet completion) in; sel (one-hot winner), vld out.
module rr_arb2 #(
  parameter int PRIO0 = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] done,
  output logic [1:0] sel,
  output logic       vld
);

  // 1 = port 1 was served most recently; reset value lets port 0 win the first tie.
  logic last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (done[0]) begin
      last <= 1'b0;
    end else if (done[1]) begin
      last <= 1'b1;
    end
  end

  always_comb begin
    sel = 2'b00;
    unique case (req)
      2'b01:   sel = 2'b01;
      2'b10:   sel = 2'b10;
      2'b11:   sel = ((PRIO0 != 0) || last) ? 2'b01 : 2'b10;
      default: sel = 2'b00;
    endcase
  end

  assign vld = |req;

endmodule

// File: rtl/osd_cmd_arbiter.sv
// osd_cmd_arbiter: serializes command packets from two requesters onto the OSD io_osd/io_strobe/io_din port.
// Latency: grant and command strobe one cycle after req in IDLE; one word per 1+STROBE_GAP cycles at best.
// Backpressure: a granted port with dvalid low parks the FSM in WAIT (io_osd held high) indefinitely.
// Ports: clk_sys/reset_n; req, cmd0/1, len0/1 request side; dvalid, dat0/1 in and dready out data side;
//        gnt, done, busy status; io_osd, io_strobe, io_din toward the OSD. All outputs are registered.
module osd_cmd_arbiter
  import osd_pkg::*;
#(
  parameter int STROBE_GAP = 1,
  parameter int END_GAP    = 2,
  parameter int PRIO0      = 0
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic [1:0]           req,
  input  logic [7:0]           cmd0,
  input  logic [7:0]           cmd1,
  input  logic [OSD_LEN_W-1:0] len0,
  input  logic [OSD_LEN_W-1:0] len1,
  input  logic [1:0]           dvalid,
  input  logic [15:0]          dat0,
  input  logic [15:0]          dat1,
  output logic [1:0]           dready,
  output logic [1:0]           gnt,
  output logic [1:0]           done,
  output logic                 io_osd,
  output logic                 io_strobe,
  output logic [15:0]          io_din,
  output logic                 busy
);

  localparam logic [OSD_CNT_W-1:0] SG_LAST  = OSD_CNT_W'(STROBE_GAP - 1);
  localparam logic [OSD_CNT_W-1:0] EG_LAST  = OSD_CNT_W'(END_GAP - 1);
  localparam logic [OSD_CNT_W-1:0] EG_DONE  = OSD_CNT_W'(END_GAP - 2);

  osd_state_t           state, state_nxt;
  logic [OSD_LEN_W-1:0] rem, rem_nxt;
  logic [OSD_CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]           gnt_nxt, dready_nxt, done_nxt;
  logic                 io_osd_nxt, io_strobe_nxt, busy_nxt;
  logic [15:0]          io_din_nxt;
  logic                 take_word;

  logic [1:0] arb_sel;
  logic       arb_vld;

  // Index of the granted port; only meaningful while gnt is non-zero.
  logic        port;
  logic        dv_g;
  logic [15:0] dat_g;

  assign port  = gnt[1];
  assign dv_g  = dvalid[port];
  assign dat_g = port ? dat1 : dat0;

  rr_arb2 #(.PRIO0(PRIO0)) u_arb (
    .clk   (clk_sys),
    .rst_n (reset_n),
    .req   (req),
    .done  (done),
    .sel   (arb_sel),
    .vld   (arb_vld)
  );

  // Outputs are computed for the coming cycle and registered together with the
  // state, so every output reflects the state it is shown in.
  always_comb begin
    state_nxt     = state;
    rem_nxt       = rem;
    cnt_nxt       = cnt;
    gnt_nxt       = gnt;
    dready_nxt    = 2'b00;
    done_nxt      = 2'b00;
    io_osd_nxt    = io_osd;
    io_strobe_nxt = 1'b0;
    io_din_nxt    = io_din;   // holds last word between strobes
    take_word     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (arb_vld) begin
          state_nxt     = ST_CMD;
          gnt_nxt       = arb_sel;
          io_osd_nxt    = 1'b1;
          io_strobe_nxt = 1'b1;
          io_din_nxt    = {8'h00, (arb_sel[1] ? cmd1 : cmd0)};
          rem_nxt       = arb_sel[1] ? len1 : len0;
        end
      end
      ST_CMD, ST_DAT: begin
        state_nxt = ST_GAP;
        cnt_nxt   = '0;
      end
      ST_GAP: begin
        if (cnt == SG_LAST) begin
          if (rem == '0) begin
            state_nxt  = ST_END;
            io_osd_nxt = 1'b0;
            cnt_nxt    = '0;
          end else if (dv_g) begin
            take_word = 1'b1;
          end else begin
            state_nxt = ST_WAIT;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_WAIT: begin
        if (dv_g) begin
          take_word = 1'b1;
        end
      end
      ST_END: begin
        // done is registered, so it is set one cycle early to land on the last END cycle.
        if (cnt == EG_DONE) begin
          done_nxt = gnt;
        end
        if (cnt == EG_LAST) begin
          state_nxt = ST_IDLE;
          gnt_nxt   = 2'b00;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (take_word) begin
      state_nxt     = ST_DAT;
      io_strobe_nxt = 1'b1;
      io_din_nxt    = dat_g;
      dready_nxt    = gnt;     // one-hot, so never reaches the other port
      rem_nxt       = rem - 1'b1;
    end

    busy_nxt = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      rem       <= '0;
      cnt       <= '0;
      gnt       <= 2'b00;
      dready    <= 2'b00;
      done      <= 2'b00;
      io_osd    <= 1'b0;
      io_strobe <= 1'b0;
      io_din    <= 16'h0000;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      rem       <= rem_nxt;
      cnt       <= cnt_nxt;
      gnt       <= gnt_nxt;
      dready    <= dready_nxt;
      done      <= done_nxt;
      io_osd    <= io_osd_nxt;
      io_strobe <= io_strobe_nxt;
      io_din    <= io_din_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_osd_cmd_arbiter.sv
// Testbench for osd_cmd_arbiter: directed phases with random data/stalls checked against a packet-level model.
// The model predicts the arbitration winner and the exact word stream of every packet.
// A second instance with PRIO0=1 checks fixed-priority granting.
module tb_osd_cmd_arbiter;
  import osd_pkg::*;

  localparam int SG = 1;
  localparam int EG = 2;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        reset_n;
  logic [1:0]  req, dvalid, dready, gnt, done;
  logic [7:0]  cmd0, cmd1;
  logic [12:0] len0, len1;
  logic [15:0] dat0, dat1, io_din;
  logic        io_osd, io_strobe, busy;

  logic [1:0]  req_p, dvalid_p, dready_p, gnt_p, done_p;
  logic [7:0]  cmd0_p, cmd1_p;
  logic [12:0] len0_p, len1_p;
  logic [15:0] dat0_p, dat1_p, io_din_p;
  logic        io_osd_p, io_strobe_p, busy_p;

  osd_cmd_arbiter #(.STROBE_GAP(SG), .END_GAP(EG), .PRIO0(0)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .req(req), .cmd0(cmd0), .cmd1(cmd1),
    .len0(len0), .len1(len1), .dvalid(dvalid), .dat0(dat0), .dat1(dat1),
    .dready(dready), .gnt(gnt), .done(done), .io_osd(io_osd),
    .io_strobe(io_strobe), .io_din(io_din), .busy(busy)
  );

  osd_cmd_arbiter #(.STROBE_GAP(SG), .END_GAP(EG), .PRIO0(1)) dut_p (
    .clk_sys(clk_sys), .reset_n(reset_n), .req(req_p), .cmd0(cmd0_p), .cmd1(cmd1_p),
    .len0(len0_p), .len1(len1_p), .dvalid(dvalid_p), .dat0(dat0_p), .dat1(dat1_p),
    .dready(dready_p), .gnt(gnt_p), .done(done_p), .io_osd(io_osd_p),
    .io_strobe(io_strobe_p), .io_din(io_din_p), .busy(busy_p)
  );

  int checks = 0;
  int errors = 0;

  // Pending packets per port, feed queues for granted data, expected strobe words.
  logic [7:0]  pc0[$], pc1[$];
  int          pl0[$], pl1[$];
  logic [15:0] pd0[$], pd1[$];
  logic [15:0] f0[$], f1[$];
  logic [15:0] exp_q[$];
  int          order_q[$];
  int          ivals[$];
  logic [1:0]  gp_q[$];

  int cyc = 0, last_m = 1, cur = -1, cur_len = 0, cmd_cyc = 0;
  int dr_cnt = 0, falls = 0, low_run = 0, gap_err = 0, stray = 0;
  int last_strobe = -1, pkt_strobes = 0, finished = 0;
  int st[2];
  int force_st1 = 0;
  bit stalls_on = 0, noise_on = 0, exact = 1;
  logic [1:0] prev_gnt = 2'b00, prev_gnt_p = 2'b00;
  logic       prev_osd = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic enqueue(input bit p, input logic [7:0] c, input int l, input bit rnd);
    logic [15:0] d;
    if (p) begin pc1.push_back(c); pl1.push_back(l); end
    else   begin pc0.push_back(c); pl0.push_back(l); end
    for (int i = 0; i < l; i++) begin
      d = rnd ? 16'($urandom) : 16'(16'h00A1 + i);
      if (p) pd1.push_back(d); else pd0.push_back(d);
    end
  endtask

  task automatic start_packet(input bit w);
    logic [7:0]  c;
    int          l;
    logic [15:0] d;
    if (w) begin c = pc1.pop_front(); l = pl1.pop_front(); end
    else   begin c = pc0.pop_front(); l = pl0.pop_front(); end
    exp_q.push_back({8'h00, c});
    for (int i = 0; i < l; i++) begin
      if (w) begin d = pd1.pop_front(); f1.push_back(d); end
      else   begin d = pd0.pop_front(); f0.push_back(d); end
      exp_q.push_back(d);
    end
    cur = w ? 1 : 0; cur_len = l; cmd_cyc = cyc;
    dr_cnt = 0; falls = 0; pkt_strobes = 0; last_strobe = -1;
    ivals.delete();
  endtask

  task automatic feed(input bit p);
    int sz;
    sz = p ? f1.size() : f0.size();
    if (dready[p] && sz > 0) begin
      if (p) void'(f1.pop_front()); else void'(f0.pop_front());
      sz--;
      dvalid[p] = 1'b0;
      if (p && force_st1 > 0) begin st[p] = force_st1; force_st1 = 0; end
      else st[p] = stalls_on ? int'($urandom_range(0, 3)) : 0;
    end else if (!dvalid[p] && st[p] > 0) begin
      st[p]--;
    end
    if (sz > 0) begin
      if (p) dat1 = f1[0]; else dat0 = f0[0];
      if (!dvalid[p] && st[p] == 0) dvalid[p] = 1'b1;
    end else begin
      // Junk on a port with nothing granted must be ignored by the DUT.
      dvalid[p] = noise_on ? 1'($urandom_range(0, 1)) : 1'b0;
      if (p) dat1 = 16'($urandom); else dat0 = 16'($urandom);
    end
  endtask

  task automatic step();
    bit w;
    @(negedge clk_sys);
    cyc++;
    if (gnt != 2'b00 && prev_gnt == 2'b00) begin
      order_q.push_back(gnt[1] ? 1 : 0);
      if (req == 2'b00) begin
        chk("spurious_grant", 32'(gnt), 32'(0));
      end else begin
        w = (req == 2'b11) ? (last_m == 0) : req[1];
        chk("grant", 32'(gnt), 32'(2'b01 << w));
        start_packet(w);
      end
    end
    if (io_strobe) begin
      chk("osd_on_strobe", 32'(io_osd), 32'(1));
      if (exp_q.size() > 0) chk("word", 32'(io_din), 32'(exp_q.pop_front()));
      else chk("unexpected_strobe", 32'(io_strobe), 32'(0));
      if (last_strobe >= 0) begin
        ivals.push_back(cyc - last_strobe);
        if (cyc - last_strobe < 1 + SG) gap_err++;
      end
      last_strobe = cyc;
      pkt_strobes++;
    end
    if (cur >= 0 && dready[cur]) dr_cnt++;
    if ((dready & ~gnt) != 2'b00) stray++;
    if (prev_osd && !io_osd && gnt != 2'b00) falls++;
    if (busy && !io_osd) low_run++; else low_run = 0;
    if (done != 2'b00) begin
      if (cur < 0) begin
        chk("spurious_done", 32'(done), 32'(0));
      end else begin
        chk("done_port", 32'(done), 32'(2'b01 << cur));
        chk("end_gap", 32'(low_run), 32'(EG));
        chk("osd_falls", 32'(falls), 32'(1));
        chk("dready_count", 32'(dr_cnt), 32'(cur_len));
        if (exact) chk("pkt_cycles", 32'(cyc - cmd_cyc), 32'((cur_len + 1) * (1 + SG) + EG - 1));
        last_m = cur; cur = -1; finished++;
      end
    end
    if (gnt_p != 2'b00 && prev_gnt_p == 2'b00) gp_q.push_back(gnt_p);
    prev_gnt = gnt; prev_gnt_p = gnt_p; prev_osd = io_osd;
    // drive
    req[0] = (pl0.size() > 0);
    req[1] = (pl1.size() > 0);
    cmd0 = (pl0.size() > 0) ? pc0[0] : 8'h00;
    cmd1 = (pl1.size() > 0) ? pc1[0] : 8'h00;
    len0 = (pl0.size() > 0) ? 13'(pl0[0]) : 13'd0;
    len1 = (pl1.size() > 0) ? 13'(pl1[0]) : 13'd0;
    feed(1'b0);
    feed(1'b1);
  endtask

  task automatic run_all(input int max);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < max; n++) begin
      step();
      if (pl0.size() == 0 && pl1.size() == 0 && cur < 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("run_complete", 32'(ok), 32'(1));
  endtask

  initial begin
    int rr_exp[4];
    int fin0;
    bit hit;
    reset_n = 1'b0; req = 2'b00; dvalid = 2'b00;
    cmd0 = 8'h00; cmd1 = 8'h00; len0 = 13'd0; len1 = 13'd0; dat0 = 16'h0; dat1 = 16'h0;
    req_p = 2'b00; dvalid_p = 2'b11; cmd0_p = OSD_CMD_WRITE; cmd1_p = OSD_CMD_ENABLE;
    len0_p = 13'd1; len1_p = 13'd1; dat0_p = 16'h1111; dat1_p = 16'h2222;
    st[0] = 0; st[1] = 0;

    // Reset with both ports requesting zero-length packets.
    enqueue(1'b0, OSD_CMD_ENABLE, 0, 1'b0);
    enqueue(1'b1, OSD_CMD_DISABLE, 0, 1'b0);
    step(); step();
    chk("reset_outputs", 32'({io_osd, io_strobe, io_din, gnt, dready, done, busy}), 32'(0));
    reset_n = 1'b1;
    step();
    chk("first_gnt", 32'(gnt), 32'(2'b01));
    chk("first_din", 32'(io_din), 32'(16'h0041));
    chk("first_osd", 32'(io_osd), 32'(1));
    chk("first_strobe", 32'(io_strobe), 32'(1));
    run_all(200);

    // Write packet, data always valid: strobes every 2 cycles.
    enqueue(1'b0, OSD_CMD_WRITE, 4, 1'b0);
    run_all(200);
    chk("write_strobes", 32'(ivals.size()), 32'(4));
    for (int i = 0; i < 4; i++) chk("write_interval", 32'(ivals[i]), 32'(2));

    // Stall before second word of port 1.
    exact = 1'b0; force_st1 = 5;
    enqueue(1'b1, OSD_CMD_WRITE, 2, 1'b1);
    run_all(200);
    chk("stall_interval", 32'(ivals[1]), 32'(6));
    exact = 1'b1;

    // Round-robin with both ports requesting continuously.
    order_q.delete();
    enqueue(1'b0, OSD_CMD_WRITE, 1, 1'b1); enqueue(1'b0, OSD_CMD_WRITE, 1, 1'b1);
    enqueue(1'b1, OSD_CMD_WRITE, 1, 1'b1); enqueue(1'b1, OSD_CMD_WRITE, 1, 1'b1);
    run_all(300);
    rr_exp = '{0, 1, 0, 1};
    for (int i = 0; i < 4; i++) chk("rr_order", 32'(order_q[i]), 32'(rr_exp[i]));

    // Fixed priority instance: port 0 always wins.
    req_p = 2'b11;
    repeat (40) step();
    req_p = 2'b00;
    repeat (12) step();
    chk("prio_grants", 32'(gp_q.size() >= 3), 32'(1));
    for (int i = 0; i < 3; i++) chk("prio_gnt", 32'(gp_q[i]), 32'(2'b01));

    // Reset after the second data strobe.
    enqueue(1'b0, OSD_CMD_WRITE, 4, 1'b1);
    hit = 1'b0;
    for (int n = 0; n < 100; n++) begin
      step();
      if (cur == 0 && pkt_strobes >= 3) begin hit = 1'b1; break; end
    end
    chk("reached_2nd_data", 32'(hit), 32'(1));
    #2 reset_n = 1'b0;
    #1 chk("async_reset", 32'({io_osd, io_strobe, io_din, gnt, dready, done, busy}), 32'(0));
    pc0.delete(); pc1.delete(); pl0.delete(); pl1.delete(); pd0.delete(); pd1.delete();
    f0.delete(); f1.delete(); exp_q.delete();
    cur = -1; last_m = 1; st[0] = 0; st[1] = 0; dvalid = 2'b00; req = 2'b00; low_run = 0;
    step(); step();
    reset_n = 1'b1;
    enqueue(1'b1, OSD_CMD_ENABLE, 2, 1'b1);
    run_all(200);

    // Random packets with random stalls and junk on idle ports.
    exact = 1'b0; stalls_on = 1'b1; noise_on = 1'b1;
    fin0 = finished;
    for (int k = 0; k < 12; k++)
      enqueue(1'($urandom_range(0, 1)), 8'($urandom), int'($urandom_range(0, 6)), 1'b1);
    run_all(3000);
    chk("random_packets", 32'(finished - fin0), 32'(12));
    noise_on = 1'b0; stalls_on = 1'b0;
    step();

    chk("gap_violations", 32'(gap_err), 32'(0));
    chk("stray_dready", 32'(stray), 32'(0));
    chk("leftover_words", 32'(exp_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
